// File: rtl/bp_predictor.sv
// 2-bit saturating-counter branch predictor fronting the prediction cache; BP_STATS_EN adds stat counters.
// Latency: guess/mispredict combinational; cache write one cycle after resolve (bypass covers the gap).
// Backpressure: none, one guess and one resolve accepted every cycle.
`timescale 1ns/1ps
module bp_predictor #(
  parameter int PC_WIDTH   = 32,
  parameter int CA_AWIDTH  = 30,
  parameter int CTR_WIDTH  = 2,
  parameter int STAT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [PC_WIDTH-1:0]   pc_guess,
  input  logic                  is_br_guess,
  output logic                  br_pred_taken,
  input  logic [PC_WIDTH-1:0]   pc_check,
  input  logic                  is_br_check,
  input  logic                  br_taken_check,
  input  logic                  guess_check,
  output logic                  mispredict,
  output logic [CA_AWIDTH-1:0]  ca0_addr,
  input  logic [CTR_WIDTH-1:0]  ca0_dout,
  input  logic                  ca0_hit,
  output logic [CA_AWIDTH-1:0]  ca1_addr,
  input  logic [CTR_WIDTH-1:0]  ca1_dout,
  input  logic                  ca1_hit,
  output logic [CA_AWIDTH-1:0]  cw_addr,
  output logic [CTR_WIDTH-1:0]  cw_din,
  output logic                  cw_we,
  output logic [STAT_WIDTH-1:0] stat_branches,
  output logic [STAT_WIDTH-1:0] stat_mispredicts
);

  generate
    if (CTR_WIDTH != 2) begin : g_bad_ctr_width
      $error("bp_predictor: CTR_WIDTH must be 2");
    end
  endgenerate

  localparam logic [CTR_WIDTH-1:0] WEAK_T  = CTR_WIDTH'(2);
  localparam logic [CTR_WIDTH-1:0] WEAK_NT = CTR_WIDTH'(1);

  logic                 upd_valid;
  logic [CA_AWIDTH-1:0] upd_addr;
  logic [CTR_WIDTH-1:0] upd_data;

  logic                 g_bypass;
  logic [CTR_WIDTH-1:0] g_ctr;
  logic                 c_bypass;
  logic                 c_known;
  logic [CTR_WIDTH-1:0] c_base;
  logic [CTR_WIDTH-1:0] c_new;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc_guess, pc_check};

  assign ca0_addr = pc_guess[CA_AWIDTH+1:2];
  assign ca1_addr = pc_check[CA_AWIDTH+1:2];

  assign mispredict = is_br_check & (guess_check ^ br_taken_check);

  // The pending write has not reached the cache yet, so it takes priority over cache data.
  always_comb begin
    g_bypass      = upd_valid && (upd_addr == ca0_addr);
    g_ctr         = g_bypass ? upd_data : ca0_dout;
    br_pred_taken = is_br_guess & (g_bypass | ca0_hit) & g_ctr[CTR_WIDTH-1];
  end

  always_comb begin
    c_bypass = upd_valid && (upd_addr == ca1_addr);
    c_known  = c_bypass | ca1_hit;
    c_base   = c_bypass ? upd_data : ca1_dout;
    c_new    = br_taken_check ? WEAK_T : WEAK_NT;
    if (c_known) begin
      if (br_taken_check)
        c_new = (c_base == '1) ? c_base : c_base + 1'b1;
      else
        c_new = (c_base == '0) ? c_base : c_base - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      upd_valid <= 1'b0;
      upd_addr  <= '0;
      upd_data  <= '0;
    end else begin
      upd_valid <= is_br_check;
      if (is_br_check) begin
        upd_addr <= ca1_addr;
        upd_data <= c_new;
      end
    end
  end

  assign cw_we   = upd_valid;
  assign cw_addr = upd_addr;
  assign cw_din  = upd_data;

`ifdef BP_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (is_br_check && (stat_branches != '1))
        stat_branches <= stat_branches + 1'b1;
      if (mispredict && (stat_mispredicts != '1))
        stat_mispredicts <= stat_mispredicts + 1'b1;
    end
  end
`else
  assign stat_branches    = '0;
  assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_bp_predictor.sv
// Bench for bp_predictor: vector table plus hand sequences, cache writes checked through a scoreboard.
`timescale 1ns/1ps
module tb_bp_predictor;
  localparam int PW = 32;
  localparam int AW = 30;
  localparam int CW = 2;
  localparam int SW = 4;
`ifdef BP_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk, reset;
  logic [PW-1:0] pc_guess, pc_check;
  logic          is_br_guess, is_br_check, br_taken_check, guess_check;
  logic          br_pred_taken, mispredict;
  logic [AW-1:0] ca0_addr, ca1_addr, cw_addr;
  logic [CW-1:0] ca0_dout, ca1_dout, cw_din;
  logic          ca0_hit, ca1_hit, cw_we;
  logic [SW-1:0] stat_branches, stat_mispredicts;

  bp_predictor #(.PC_WIDTH(PW), .CA_AWIDTH(AW), .CTR_WIDTH(CW), .STAT_WIDTH(SW)) dut (
    .clk(clk), .reset(reset),
    .pc_guess(pc_guess), .is_br_guess(is_br_guess), .br_pred_taken(br_pred_taken),
    .pc_check(pc_check), .is_br_check(is_br_check), .br_taken_check(br_taken_check),
    .guess_check(guess_check), .mispredict(mispredict),
    .ca0_addr(ca0_addr), .ca0_dout(ca0_dout), .ca0_hit(ca0_hit),
    .ca1_addr(ca1_addr), .ca1_dout(ca1_dout), .ca1_hit(ca1_hit),
    .cw_addr(cw_addr), .cw_din(cw_din), .cw_we(cw_we),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  // Behavioural prediction cache: async reads, write at the clock edge, not touched by reset.
  logic [CW-1:0] cmem [0:511];
  logic          cval [0:511];
  logic          cache_clr;

  always @(posedge clk) begin
    if (cache_clr) begin
      for (int i = 0; i < 512; i++) cval[i] <= 1'b0;
    end else if (cw_we) begin
      cval[cw_addr[8:0]] <= 1'b1;
      cmem[cw_addr[8:0]] <= cw_din;
    end
  end

  assign ca0_hit  = cval[ca0_addr[8:0]];
  assign ca0_dout = cmem[ca0_addr[8:0]];
  assign ca1_hit  = cval[ca1_addr[8:0]];
  assign ca1_dout = cmem[ca1_addr[8:0]];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rst;
    logic [31:0] pcg;
    logic        bg;
    logic [31:0] pcc;
    logic        bc;
    logic        tk;
    logic        gc;
    logic        ep;   // expected br_pred_taken
    logic        em;   // expected mispredict
    logic [1:0]  ed;   // expected counter written for this resolve
  } vec_t;

  typedef struct {
    int            due;
    logic [AW-1:0] addr;
    logic [1:0]    din;
  } wr_t;

  wr_t  sb[$];
  int   cyc;
  int   n_tests;
  int   n_fail;
  vec_t tbl [24];

  function automatic vec_t mk(logic rst, logic [31:0] pcg, logic bg, logic [31:0] pcc,
                              logic bc, logic tk, logic gc, logic ep, logic em, logic [1:0] ed);
    vec_t v;
    v.rst = rst; v.pcg = pcg; v.bg = bg; v.pcc = pcc; v.bc = bc;
    v.tk = tk; v.gc = gc; v.ep = ep; v.em = em; v.ed = ed;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_stats(input string nm, input int b, input int m);
    chk({nm, ".stat_branches"}, 32'(stat_branches), STATS ? 32'(b) : 32'd0);
    chk({nm, ".stat_mispredicts"}, 32'(stat_mispredicts), STATS ? 32'(m) : 32'd0);
  endtask

  task automatic step(input vec_t v, input string tag);
    wr_t w;
    logic [AW-1:0] ea0, ea1;
    reset = v.rst; pc_guess = v.pcg; is_br_guess = v.bg; pc_check = v.pcc;
    is_br_check = v.bc; br_taken_check = v.tk; guess_check = v.gc;
    ea0 = v.pcg[AW+1:2];
    ea1 = v.pcc[AW+1:2];
    #4;
    chk({tag, ".pred"}, 32'(br_pred_taken), 32'(v.ep));
    chk({tag, ".mispredict"}, 32'(mispredict), 32'(v.em));
    chk({tag, ".ca0_addr"}, 32'(ca0_addr), 32'(ea0));
    chk({tag, ".ca1_addr"}, 32'(ca1_addr), 32'(ea1));
    if (v.bc && !v.rst) begin
      w.due = cyc + 1; w.addr = ea1; w.din = v.ed;
      sb.push_back(w);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      w = sb.pop_front();
      chk({tag, ".cw_we"}, 32'(cw_we), 32'd1);
      chk({tag, ".cw_addr"}, 32'(cw_addr), 32'(w.addr));
      chk({tag, ".cw_din"}, 32'(cw_din), 32'(w.din));
    end else begin
      chk({tag, ".cw_we"}, 32'(cw_we), 32'd0);
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0;
    reset = 1'b1; cache_clr = 1'b1;
    pc_guess = '0; pc_check = '0; is_br_guess = 1'b0; is_br_check = 1'b0;
    br_taken_check = 1'b0; guess_check = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cache_clr = 1'b0;
    reset = 1'b0;
    chk("reset.cw_we", 32'(cw_we), 32'd0);
    chk("reset.cw_addr", 32'(cw_addr), 32'd0);
    chk("reset.cw_din", 32'(cw_din), 32'd0);
    chk_stats("reset", 0, 0);

    //            rst pcg    bg pcc    bc tk gc  ep em ed
    tbl[0]  = mk(0, 'h100, 1, 'h000, 0, 0, 0, 0, 0, 2'b00); // cold miss
    tbl[1]  = mk(0, 'h100, 1, 'h100, 1, 1, 0, 0, 1, 2'b10); // same-cycle guess sees old
    tbl[2]  = mk(0, 'h100, 1, 'h000, 0, 0, 0, 1, 0, 2'b00); // bypass
    tbl[3]  = mk(0, 'h100, 1, 'h000, 0, 0, 0, 1, 0, 2'b00); // from cache
    tbl[4]  = mk(0, 'h200, 1, 'h200, 1, 1, 1, 0, 0, 2'b10);
    tbl[5]  = mk(0, 'h200, 0, 'h200, 1, 1, 1, 0, 0, 2'b11);
    tbl[6]  = mk(0, 'h200, 0, 'h200, 1, 1, 1, 0, 0, 2'b11);
    tbl[7]  = mk(0, 'h200, 0, 'h200, 1, 1, 1, 0, 0, 2'b11);
    tbl[8]  = mk(0, 'h200, 0, 'h200, 1, 1, 1, 0, 0, 2'b11);
    tbl[9]  = mk(0, 'h200, 1, 'h000, 0, 0, 0, 1, 0, 2'b00);
    tbl[10] = mk(0, 'h200, 0, 'h200, 0, 1, 0, 0, 0, 2'b00); // no branch either side
    tbl[11] = mk(0, 'h300, 1, 'h300, 1, 0, 0, 0, 0, 2'b01);
    tbl[12] = mk(0, 'h300, 1, 'h000, 0, 0, 0, 0, 0, 2'b00);
    tbl[13] = mk(0, 'h300, 1, 'h300, 1, 0, 1, 0, 1, 2'b00); // base from cache 01
    tbl[14] = mk(0, 'h300, 0, 'h300, 1, 0, 0, 0, 0, 2'b00);
    tbl[15] = mk(0, 'h300, 0, 'h300, 1, 0, 0, 0, 0, 2'b00);
    tbl[16] = mk(0, 'h300, 1, 'h000, 0, 0, 0, 0, 0, 2'b00);
    tbl[17] = mk(0, 'h400, 1, 'h400, 1, 1, 1, 0, 0, 2'b10);
    tbl[18] = mk(0, 'h400, 1, 'h000, 0, 0, 0, 1, 0, 2'b00); // bypass before cache write
    tbl[19] = mk(0, 'h100, 1, 'h100, 1, 0, 1, 1, 1, 2'b01); // 10 -> 01
    tbl[20] = mk(0, 'h100, 1, 'h000, 0, 0, 0, 0, 0, 2'b00);
    tbl[21] = mk(0, 'h100, 1, 'h000, 0, 0, 0, 0, 0, 2'b00);
    tbl[22] = mk(0, 'h100, 1, 'h100, 1, 1, 0, 0, 1, 2'b10); // 01 -> 10
    tbl[23] = mk(0, 'h100, 1, 'h000, 0, 0, 0, 1, 0, 2'b00);

    for (int i = 0; i < 24; i++) step(tbl[i], $sformatf("row%0d", i));
    chk_stats("table", 13, 4);

    // Stats: reset clears, then 4 branches with 3 mispredicts.
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00), "st_rst");
    chk_stats("st_rst", 0, 0);
    step(mk(0, 'h700, 0, 'h700, 1, 1, 0, 0, 1, 2'b10), "st0");
    step(mk(0, 'h700, 0, 'h700, 1, 1, 0, 0, 1, 2'b11), "st1");
    step(mk(0, 'h700, 0, 'h700, 1, 1, 0, 0, 1, 2'b11), "st2");
    step(mk(0, 'h700, 0, 'h700, 1, 1, 1, 0, 0, 2'b11), "st3");
    chk_stats("st4", 4, 3);

    // Statistic saturation at all-ones.
    for (int i = 0; i < 20; i++)
      step(mk(0, 'h700, 0, 'h700, 1, 1, 0, 0, 1, 2'b11), $sformatf("sat%0d", i));
    chk_stats("sat", 15, 15);

    // Reset right after a resolve: the pending write still lands, then cw_we drops.
    step(mk(0, 'h000, 0, 'h500, 1, 1, 0, 0, 1, 2'b10), "rm_res");
    step(mk(1, 'h000, 0, 'h000, 0, 0, 0, 0, 0, 2'b00), "rm_rst");
    chk_stats("rm_rst", 0, 0);
    // A resolve during reset is dropped.
    step(mk(1, 'h000, 0, 'h600, 1, 1, 1, 0, 0, 2'b10), "rd_rst");
    step(mk(0, 'h600, 1, 'h000, 0, 0, 0, 0, 0, 2'b00), "rd_miss");
    step(mk(0, 'h500, 1, 'h000, 0, 0, 0, 1, 0, 2'b00), "rm_landed");
    chk_stats("rd_end", 0, 0);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
